// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute over the shared
// datapath, with a req/ready memory handshake guarded by a watchdog.
module mc_ctrl_fsm #(
   parameter int unsigned WAIT_W   = 8,
   parameter int unsigned MAX_WAIT = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic       bus_err,
   output logic       retire,
   output logic [3:0] state
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      MEMADR = 4'd3,
      MEMRD  = 4'd4,
      MEMWB  = 4'd5,
      MEMWR  = 4'd6,
      REX    = 4'd7,
      RWB    = 4'd8,
      BEQ    = 4'd9,
      JMP    = 4'd10,
      ADDIEX = 4'd11,
      ADDIWB = 4'd12
   } stateT;

   stateT             stateQ;
   stateT             stateD;
   logic [WAIT_W-1:0] waitCnt;
   logic [5:0]        opReg;
   logic              atMax;
   logic              waitState;
   logic              timeout;

   assign atMax = (waitCnt == WAIT_W'(MAX_WAIT));
   assign state = 4'(stateQ);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stateQ <= IDLE;
      else        stateQ <= stateD;
   end

   // Watchdog: restarts on any state change or timeout, saturates while waiting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waitCnt <= '0;
      end else if ((stateD != stateQ) || timeout) begin
         waitCnt <= '0;
      end else if (waitState && !mem_ready && (waitCnt != {WAIT_W{1'b1}})) begin
         waitCnt <= waitCnt + WAIT_W'(1);
      end
   end

   // Opcode held for the MEMADR lw/sw split
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                opReg <= '0;
      else if (stateQ == DECODE) opReg <= opcode;
   end

   // Next state and datapath controls
   always_comb begin
      stateD        = stateQ;
      waitState     = 1'b0;
      timeout       = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
      bus_err       = 1'b0;
      retire        = 1'b0;
      unique case (stateQ)
         IDLE: stateD = FETCH;
         FETCH: begin
            waitState = 1'b1;
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               stateD   = DECODE;
            end else if (atMax) begin
               bus_err = 1'b1;
               timeout = 1'b1;
               stateD  = FETCH;
            end
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_RTYPE:     stateD = REX;
               OP_LW, OP_SW: stateD = MEMADR;
               OP_BEQ:       stateD = BEQ;
               OP_J:         stateD = JMP;
               OP_ADDI:      stateD = ADDIEX;
               default: begin
                  illegal_op = 1'b1;
                  stateD     = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            stateD    = (opReg == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            waitState = 1'b1;
            i_or_d    = 1'b1;
            mem_read  = 1'b1;
            if (mem_ready) begin
               stateD = MEMWB;
            end else if (atMax) begin
               bus_err = 1'b1;
               timeout = 1'b1;
               stateD  = FETCH;
            end
         end
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            retire     = 1'b1;
            stateD     = FETCH;
         end
         MEMWR: begin
            waitState = 1'b1;
            i_or_d    = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               retire = 1'b1;
               stateD = FETCH;
            end else if (atMax) begin
               bus_err = 1'b1;
               timeout = 1'b1;
               stateD  = FETCH;
            end
         end
         REX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            stateD    = RWB;
         end
         RWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            retire    = 1'b1;
            stateD    = FETCH;
         end
         BEQ: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_source     = 2'b01;
            pc_write_cond = 1'b1;
            retire        = 1'b1;
            stateD        = FETCH;
         end
         JMP: begin
            pc_source = 2'b10;
            pc_write  = 1'b1;
            retire    = 1'b1;
            stateD    = FETCH;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            stateD    = ADDIWB;
         end
         ADDIWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            stateD    = FETCH;
         end
         default: stateD = FETCH;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle state and control-word checks
// against hand-computed constants, with a short watchdog limit.
module tb_mc_ctrl_fsm;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic       illegal_op, bus_err, retire;
   logic [3:0] state;
   logic [19:0] ctl;

   int nChecks = 0;
   int nPass   = 0;

   mc_ctrl_fsm #(.WAIT_W(8), .MAX_WAIT(5)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .bus_err(bus_err),
      .retire(retire), .state(state)
   );

   // pcW pcWC iOrD mRd mWr irW m2r rDst rW srcA srcB[2] aluOp[2] pcSrc[2] ill berr ret
   assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_source, illegal_op, bus_err, retire};

   localparam logic [19:0] C_ZERO   = 20'b0;
   localparam logic [19:0] C_FWAIT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_FRDY   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_FTOUT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b1,1'b0};
   localparam logic [19:0] C_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_DECILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1,1'b0,1'b0};
   localparam logic [19:0] C_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_MEMRD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1};
   localparam logic [19:0] C_WRWAIT = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_WRRDY  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1};
   localparam logic [19:0] C_WRTOUT = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0};
   localparam logic [19:0] C_REX    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1};
   localparam logic [19:0] C_BEQ    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0,1'b1};
   localparam logic [19:0] C_JMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b0,1'b1};
   localparam logic [19:0] C_ADDIEX = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Apply inputs for one cycle, check the combinational outputs, then advance a clock
   task automatic cyc(input string tag, input logic rdy, input logic [5:0] op,
                      input logic [3:0] expSt, input logic [19:0] expCtl);
      mem_ready = rdy;
      opcode    = op;
      #1;
      chk({tag, ".state"}, 32'(state), 32'(expSt));
      chk({tag, ".ctl"},   32'(ctl),   32'(expCtl));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      opcode    = 6'b0;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.state", 32'(state), 32'd0);
      chk("reset.ctl",   32'(ctl),   32'(C_ZERO));
      rst_n = 1'b1;

      // R-type, ready tied high: 0,1,2,7,8,1
      cyc("r.idle",   1'b1, 6'b000000, 4'd0, C_ZERO);
      cyc("r.fetch",  1'b1, 6'b000000, 4'd1, C_FRDY);
      cyc("r.decode", 1'b0, 6'b000000, 4'd2, C_DEC);
      cyc("r.rex",    1'b0, 6'b111111, 4'd7, C_REX);
      cyc("r.rwb",    1'b1, 6'b111111, 4'd8, C_RWB);

      // lw with 3 wait cycles in FETCH and MEMRD; opcode changes after DECODE
      for (int i = 0; i < 3; i++) cyc("lw.fwait", 1'b0, 6'b100011, 4'd1, C_FWAIT);
      cyc("lw.fetch",  1'b1, 6'b100011, 4'd1, C_FRDY);
      cyc("lw.decode", 1'b0, 6'b100011, 4'd2, C_DEC);
      cyc("lw.memadr", 1'b1, 6'b101011, 4'd3, C_MEMADR);
      for (int i = 0; i < 3; i++) cyc("lw.rwait", 1'b0, 6'b101011, 4'd4, C_MEMRD);
      cyc("lw.memrd",  1'b1, 6'b101011, 4'd4, C_MEMRD);
      cyc("lw.memwb",  1'b0, 6'b101011, 4'd5, C_MEMWB);

      // beq
      cyc("beq.fetch",  1'b1, 6'b000100, 4'd1, C_FRDY);
      cyc("beq.decode", 1'b1, 6'b000100, 4'd2, C_DEC);
      cyc("beq.beq",    1'b1, 6'b000100, 4'd9, C_BEQ);

      // illegal opcode
      cyc("ill.fetch",  1'b1, 6'b111111, 4'd1, C_FRDY);
      cyc("ill.decode", 1'b1, 6'b111111, 4'd2, C_DECILL);

      // sw with watchdog expiry: mem_write for counts 0..5, bus_err at 5
      cyc("swto.fetch",  1'b1, 6'b101011, 4'd1, C_FRDY);
      cyc("swto.decode", 1'b1, 6'b101011, 4'd2, C_DEC);
      cyc("swto.memadr", 1'b0, 6'b000000, 4'd3, C_MEMADR);
      for (int i = 0; i < 5; i++) cyc("swto.wait", 1'b0, 6'b000000, 4'd6, C_WRWAIT);
      cyc("swto.tout",   1'b0, 6'b000000, 4'd6, C_WRTOUT);

      // Back in FETCH; ready on the MAX_WAIT cycle wins over the timeout
      for (int i = 0; i < 5; i++) cyc("fprio.wait", 1'b0, 6'b101011, 4'd1, C_FWAIT);
      cyc("fprio.rdy",   1'b1, 6'b101011, 4'd1, C_FRDY);
      cyc("sw.decode",   1'b1, 6'b101011, 4'd2, C_DEC);
      cyc("sw.memadr",   1'b1, 6'b101011, 4'd3, C_MEMADR);
      cyc("sw.memwr",    1'b1, 6'b101011, 4'd6, C_WRRDY);

      // FETCH timeout then a fresh watchdog window
      for (int i = 0; i < 5; i++) cyc("fto.wait", 1'b0, 6'b000010, 4'd1, C_FWAIT);
      cyc("fto.tout",    1'b0, 6'b000010, 4'd1, C_FTOUT);
      for (int i = 0; i < 5; i++) cyc("fto.rewait", 1'b0, 6'b000010, 4'd1, C_FWAIT);
      cyc("j.fetch",     1'b1, 6'b000010, 4'd1, C_FRDY);
      cyc("j.decode",    1'b0, 6'b000010, 4'd2, C_DEC);
      cyc("j.jmp",       1'b0, 6'b000010, 4'd10, C_JMP);

      // addi
      cyc("addi.fetch",  1'b1, 6'b001000, 4'd1, C_FRDY);
      cyc("addi.decode", 1'b1, 6'b001000, 4'd2, C_DEC);
      cyc("addi.ex",     1'b1, 6'b001000, 4'd11, C_ADDIEX);
      cyc("addi.wb",     1'b1, 6'b001000, 4'd12, C_ADDIWB);

      // Reset asserted mid-REX
      cyc("rst.fetch",   1'b1, 6'b000000, 4'd1, C_FRDY);
      cyc("rst.decode",  1'b1, 6'b000000, 4'd2, C_DEC);
      mem_ready = 1'b1;
      #1;
      chk("rst.rex.state", 32'(state), 32'd7);
      rst_n = 1'b0;
      #1;
      chk("rst.async.state", 32'(state), 32'd0);
      chk("rst.async.ctl",   32'(ctl),   32'(C_ZERO));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc("rst.idle",    1'b1, 6'b000000, 4'd0, C_ZERO);
      cyc("rst.refetch", 1'b1, 6'b000000, 4'd1, C_FRDY);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS main controller that sequences the shared datapath (PC, IR, register file, single ALU, unified memory) over several cycles per instruction.
- Decodes opcode from IR and drives all datapath enables and muxes.
- Handles variable-latency memory through a req/ready handshake with a watchdog.
- Sits between the IR/opcode field and the datapath; its alu_op feeds the existing ALU control decoder.

Parameters:
- WAIT_W, 8: width of the memory watchdog counter.
- MAX_WAIT, 200: cycles an access may wait for mem_ready before abort (1..2^WAIT_W-1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; sampled in DECODE only
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  0=PC addresses memory, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  1=MDR to regfile write data
- reg_dst  out  1  1=rd, 0=rt
- reg_write  out  1  regfile write enable
- alu_src_a  out  1  0=PC, 1=A reg
- alu_src_b  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=use funct
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op  out  1  one-cycle pulse, unsupported opcode
- bus_err  out  1  one-cycle pulse, memory watchdog expiry
- retire  out  1  one-cycle pulse, instruction completed
- state  out  4  current state code (debug)

Behaviour:
- States/codes: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, REX 7, RWB 8, BEQ 9, JMP 10, ADDIEX 11, ADDIWB 12.
- Reset (async): state=IDLE. All outputs are decoded from state/counter and are 0 in IDLE; IDLE→FETCH after one clock unconditionally.
- FETCH: i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - mem_ready=0: hold in FETCH.
  - mem_ready=1 in that cycle: ir_write=1 and pc_write=1 (Mealy-gated on mem_ready); next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 000000→REX, 100011/101011→MEMADR, 000100→BEQ, 000010→JMP, 001000→ADDIEX.
  - Any other opcode: illegal_op=1 this cycle, next state FETCH, no retire.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD for lw (100011), MEMWR for sw; the opcode is captured into an internal register in DECODE.
- MEMRD: i_or_d=1, mem_read=1; on mem_ready go to MEMWB, otherwise hold.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, retire=1; next state FETCH.
- MEMWR: i_or_d=1, mem_write=1; on mem_ready assert retire=1 and go to FETCH, otherwise hold.
- REX: alu_src_a=1, alu_src_b=00, alu_op=10; next state RWB.
- RWB: reg_dst=1, mem_to_reg=0, reg_write=1, retire=1; next state FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1, retire=1; next state FETCH.
- JMP: pc_source=10, pc_write=1, retire=1; next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, retire=1; next state FETCH.
- Any output not listed for a state is 0.
- Watchdog:
  - Counter clears on every state change and counts up each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0; it saturates and never wraps.
  - When the counter equals MAX_WAIT and mem_ready=0: bus_err=1 for one cycle, the request drops, and the next state is FETCH. No write enable (ir_write, pc_write, reg_write) fires and there is no retire.
  - A FETCH timeout re-fetches the same PC.
  - mem_ready=1 in the same cycle the counter reaches MAX_WAIT counts as success; the ready takes priority.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- Unused state codes 13–15 go to FETCH on the next clock, with outputs 0.
- rst_n asserted mid-instruction: immediate return to IDLE with all outputs 0; the instruction is abandoned with no retire.
- Latencies with mem_ready tied to 1: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.

Test Plan:
- Reset release, mem_ready=1, opcode=000000 → state sequence 0,1,2,7,8,1; ir_write and pc_write high in cycle 1; reg_write, reg_dst and retire high in cycle 4.
- lw (100011) with mem_ready delayed 3 cycles in both FETCH and MEMRD → mem_read held high for 4 cycles each time; ir_write pulses only on the ready cycle; MEMWB has reg_write=1, mem_to_reg=1.
- beq (000100) → BEQ cycle shows alu_op=01, pc_source=01, pc_write_cond=1, pc_write=0; the next state is FETCH.
- Opcode 111111 in DECODE → illegal_op pulses once, retire=0, the next state is FETCH.
- MAX_WAIT=5 with mem_ready held 0 in MEMWR → mem_write high for cycles 0..5, bus_err pulse on the 6th cycle, then FETCH; no retire.
- rst_n pulled low for 1 cycle mid-REX → all outputs 0 asynchronously; after release the sequence is IDLE→FETCH.
